// File: rtl/instr_sender.sv
// instr_sender: FIFO-buffered producer for the app_en/app_ack/app_instr instruction handshake
`ifndef END_ISEQ
`define END_ISEQ 4'b0000
`endif
module instr_sender #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              app_en,
  input  logic              app_ack,
  output logic [31:0]       app_instr,
  output logic              busy,
  output logic [ADDR_W:0]   seq_pending,
  output logic [ADDR_W:0]   fifo_level
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] END_OP = `END_ISEQ;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0] lvl_q, lvl_d, seq_q, seq_d;
  logic push, pop, push_end, pop_end, full;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      seq_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      seq_q <= seq_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end
  always_comb begin
    full = lvl_q == (ADDR_W+1)'(DEPTH);
    push = in_valid & ~full;
    pop = app_en & app_ack;
    push_end = push & (in_data[31:28] == END_OP);
    pop_end = pop & (app_instr[31:28] == END_OP);
    wr_d = wr_q + ADDR_W'(push);
    rd_d = rd_q + ADDR_W'(pop);
    lvl_d = lvl_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    seq_d = seq_q + (ADDR_W+1)'(push_end) - (ADDR_W+1)'(pop_end);
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (seq_q != '0 || full) ? SEND : IDLE;
    else state_d = pop_end ? IDLE : SEND;
  end
  always_comb begin
    in_ready = ~full;
    app_instr = mem_q[rd_q];
    app_en = ~rst & (state_q == SEND) & (lvl_q != '0);
    busy = state_q == SEND;
    seq_pending = seq_q;
    fifo_level = lvl_q;
  end
endmodule
